// File: rtl/rv_defs.sv
// rtl/rv_defs.sv - shared RV32I opcode/function constants and predecode entry type
package rv_defs;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [2:0] FUNC_ADD = 3'b000;

    // One decoded instruction as held in the X register.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [4:0]  opcode;
        logic [2:0]  fun;
        logic        shifter_sign;
        logic [31:0] imm;
        logic        illegal;
    } x_entry_t;

    // Full 32-bit encoding with one of the supported RV32I major opcodes.
    function automatic logic is_legal(input logic [31:0] ir);
        return (ir[1:0] == 2'b11) &&
               (ir[6:2] inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP,
                                OPC_FENCE, OPC_SYSTEM});
    endfunction

endpackage

// File: rtl/rv_predecode_stage_if.sv
// rtl/rv_predecode_stage_if.sv - fetch/execute/register-file signal bundle of the predecode stage
interface rv_predecode_stage_if;
    logic        f_valid_i;
    logic [31:0] f_ir_i;
    logic [31:0] f_pc_i;
    logic        f_stall_o;
    logic        x_stall_i;
    logic        x_kill_i;
    logic        x_valid_o;
    logic [31:0] x_pc_o;
    logic [4:0]  x_rs1_o;
    logic [4:0]  x_rs2_o;
    logic [4:0]  x_rd_o;
    logic [4:0]  x_shamt_o;
    logic [4:0]  x_opcode_o;
    logic [2:0]  x_fun_o;
    logic        x_shifter_sign_o;
    logic [31:0] x_imm_o;
    logic        x_illegal_o;
    logic [4:0]  rf_rs1_o;
    logic [4:0]  rf_rs2_o;

    modport master (
        output f_valid_i, f_ir_i, f_pc_i, x_stall_i, x_kill_i,
        input  f_stall_o, x_valid_o, x_pc_o, x_rs1_o, x_rs2_o, x_rd_o, x_shamt_o,
               x_opcode_o, x_fun_o, x_shifter_sign_o, x_imm_o, x_illegal_o,
               rf_rs1_o, rf_rs2_o
    );

    modport slave (
        input  f_valid_i, f_ir_i, f_pc_i, x_stall_i, x_kill_i,
        output f_stall_o, x_valid_o, x_pc_o, x_rs1_o, x_rs2_o, x_rd_o, x_shamt_o,
               x_opcode_o, x_fun_o, x_shifter_sign_o, x_imm_o, x_illegal_o,
               rf_rs1_o, rf_rs2_o
    );
endinterface

// File: rtl/rv_imm_decode.sv
// rtl/rv_imm_decode.sv - combinational RV32I immediate formatter selected by opcode
module rv_imm_decode
    import rv_defs::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm
);

    // Pick the immediate format from the major opcode; unknown opcodes carry no immediate.
    always_comb begin
        imm = 32'h0;
        case (ir[6:2])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{ir[31]}}, ir[31:20]};
            OPC_STORE:
                imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH:
                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {ir[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:
                imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv_predecode_stage.sv
// rtl/rv_predecode_stage.sv - fetch-to-execute predecode register with optional one-entry skid buffer
module rv_predecode_stage
    import rv_defs::*;
#(
    parameter int unsigned G_WITH_SKID      = 1,
    parameter int unsigned G_DETECT_ILLEGAL = 1,
    parameter logic [31:0] G_RESET_PC       = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rv_predecode_stage_if.slave bus
);

    logic        skid_valid;
    logic [31:0] skid_ir;
    logic [31:0] skid_pc;
    logic        x_valid;
    x_entry_t    x_q;

    logic        f_stall;
    logic        accept;
    logic        load_x;
    logic        drain;
    logic        fill_x;
    logic [31:0] src_ir;
    logic [31:0] src_pc;
    logic [31:0] src_imm;
    x_entry_t    src_dec;

    // Handshake: X can load when empty or not stalled; a full skid always drains first.
    always_comb begin
        f_stall = (G_WITH_SKID != 0) ? skid_valid : (bus.x_stall_i && x_valid);
        accept  = bus.f_valid_i && !f_stall;
        load_x  = !bus.x_stall_i || !x_valid;
        drain   = skid_valid && load_x;
        fill_x  = drain || (accept && load_x);
        src_ir  = drain ? skid_ir : bus.f_ir_i;
        src_pc  = drain ? skid_pc : bus.f_pc_i;
    end

    rv_imm_decode u_imm (
        .ir  (src_ir),
        .imm (src_imm)
    );

    // Decode whichever word is about to enter X.
    always_comb begin
        src_dec              = '0;
        src_dec.pc           = src_pc;
        src_dec.rs1          = src_ir[19:15];
        src_dec.rs2          = src_ir[24:20];
        src_dec.rd           = src_ir[11:7];
        src_dec.shamt        = src_ir[24:20];
        src_dec.opcode       = src_ir[6:2];
        src_dec.shifter_sign = src_ir[30];
        src_dec.fun          = (src_ir[6:2] inside {OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC})
                               ? FUNC_ADD : src_ir[14:12];
        src_dec.imm          = src_imm;
        src_dec.illegal      = (G_DETECT_ILLEGAL != 0) && !is_legal(src_ir);
    end

    // X register: fields only change when a live word loads, so empty slots keep stale fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_valid <= 1'b0;
            x_q     <= '0;
            x_q.pc  <= G_RESET_PC;
        end else if (bus.x_kill_i) begin
            x_valid <= 1'b0;
        end else if (load_x) begin
            x_valid <= fill_x;
            if (fill_x) begin
                x_q <= src_dec;
            end
        end
    end

    // Skid entry: catches the word accepted while X is stalled, refills when drain and accept coincide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_valid <= 1'b0;
            skid_ir    <= 32'h0;
            skid_pc    <= 32'h0;
        end else if (bus.x_kill_i) begin
            skid_valid <= 1'b0;
        end else if (G_WITH_SKID != 0) begin
            if (drain) begin
                skid_valid <= accept;
                if (accept) begin
                    skid_ir <= bus.f_ir_i;
                    skid_pc <= bus.f_pc_i;
                end
            end else if (!load_x && accept) begin
                skid_valid <= 1'b1;
                skid_ir    <= bus.f_ir_i;
                skid_pc    <= bus.f_pc_i;
            end
        end
    end

    assign bus.f_stall_o        = f_stall;
    assign bus.x_valid_o        = x_valid;
    assign bus.x_pc_o           = x_q.pc;
    assign bus.x_rs1_o          = x_q.rs1;
    assign bus.x_rs2_o          = x_q.rs2;
    assign bus.x_rd_o           = x_q.rd;
    assign bus.x_shamt_o        = x_q.shamt;
    assign bus.x_opcode_o       = x_q.opcode;
    assign bus.x_fun_o          = x_q.fun;
    assign bus.x_shifter_sign_o = x_q.shifter_sign;
    assign bus.x_imm_o          = x_q.imm;
    assign bus.x_illegal_o      = x_q.illegal && x_valid;
    assign bus.rf_rs1_o         = fill_x ? src_ir[19:15] : x_q.rs1;
    assign bus.rf_rs2_o         = fill_x ? src_ir[24:20] : x_q.rs2;

endmodule

// File: tb/tb_rv_predecode_stage.sv
// tb/tb_rv_predecode_stage.sv - self-checking bench for rv_predecode_stage
module tb_rv_predecode_stage;
    import rv_defs::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_predecode_stage_if bus_a ();
    rv_predecode_stage_if bus_b ();

    rv_predecode_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    rv_predecode_stage #(
        .G_WITH_SKID      (0),
        .G_DETECT_ILLEGAL (0),
        .G_RESET_PC       (32'h80)
    ) dut_n (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fun;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rd;
    } vec_t;

    vec_t     tbl[12];
    int       n_checks = 0;
    int       n_errors = 0;
    x_entry_t sb[$];
    x_entry_t sb_got;
    x_entry_t sb_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                         input logic stall, input logic kill);
        bus_a.f_valid_i = v;  bus_b.f_valid_i = v;
        bus_a.f_ir_i    = ir; bus_b.f_ir_i    = ir;
        bus_a.f_pc_i    = pc; bus_b.f_pc_i    = pc;
        bus_a.x_stall_i = stall; bus_b.x_stall_i = stall;
        bus_a.x_kill_i  = kill;  bus_b.x_kill_i  = kill;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic x_entry_t model(input logic [31:0] ir, input logic [31:0] pc);
        x_entry_t    m;
        logic [31:0] imm;
        case (ir[6:2])
            5'b00100, 5'b00000, 5'b11001: imm = $signed(ir) >>> 20;
            5'b01000: imm = $signed({ir[31:25], ir[11:7], 20'h0}) >>> 20;
            5'b11000: imm = $signed({ir[31], ir[7], ir[30:25], ir[11:8], 20'h0}) >>> 19;
            5'b01101, 5'b00101: imm = {ir[31:12], 12'h0};
            5'b11011: imm = $signed({ir[31], ir[19:12], ir[20], ir[30:21], 12'h0}) >>> 11;
            default: imm = 32'h0;
        endcase
        m.pc           = pc;
        m.rs1          = ir[19:15];
        m.rs2          = ir[24:20];
        m.rd           = ir[11:7];
        m.shamt        = ir[24:20];
        m.opcode       = ir[6:2];
        m.shifter_sign = ir[30];
        m.fun          = (ir[6:2] == 5'b11011 || ir[6:2] == 5'b11001 ||
                          ir[6:2] == 5'b01101 || ir[6:2] == 5'b00101) ? 3'b000 : ir[14:12];
        m.imm          = imm;
        m.illegal      = (ir[1:0] != 2'b11) ||
                         !(ir[6:2] inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                                           5'b00000, 5'b01000, 5'b00100, 5'b01100,
                                           5'b00011, 5'b11100});
        return m;
    endfunction

    // Scoreboard: push on accept, pop when X hands a word to execute, flush on kill/reset.
    always @(negedge clk) begin
        if (rst || bus_a.x_kill_i) begin
            sb.delete();
        end else begin
            if (bus_a.x_valid_o && !bus_a.x_stall_i) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected: got pc %h expected no output", bus_a.x_pc_o);
                end else begin
                    sb_exp              = sb.pop_front();
                    sb_got.pc           = bus_a.x_pc_o;
                    sb_got.rs1          = bus_a.x_rs1_o;
                    sb_got.rs2          = bus_a.x_rs2_o;
                    sb_got.rd           = bus_a.x_rd_o;
                    sb_got.shamt        = bus_a.x_shamt_o;
                    sb_got.opcode       = bus_a.x_opcode_o;
                    sb_got.fun          = bus_a.x_fun_o;
                    sb_got.shifter_sign = bus_a.x_shifter_sign_o;
                    sb_got.imm          = bus_a.x_imm_o;
                    sb_got.illegal      = bus_a.x_illegal_o;
                    if (sb_got !== sb_exp) begin
                        n_errors++;
                        $display("FAIL sb_entry: got %h expected %h (pc %h/%h imm %h/%h)",
                                 sb_got, sb_exp, sb_got.pc, sb_exp.pc, sb_got.imm, sb_exp.imm);
                    end
                end
            end
            if (bus_a.f_valid_i && !bus_a.f_stall_o) begin
                sb.push_back(model(bus_a.f_ir_i, bus_a.f_pc_i));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'hFFF10093, 32'h100, 32'hFFFFFFFF, 3'd0, 1'b0, 5'd2,  5'd1};
        tbl[1]  = '{32'hFFDFF06F, 32'h104, 32'hFFFFFFFC, 3'd0, 1'b0, 5'd31, 5'd0};
        tbl[2]  = '{32'h00000000, 32'h108, 32'h00000000, 3'd0, 1'b1, 5'd0,  5'd0};
        tbl[3]  = '{32'h123452B7, 32'h10C, 32'h12345000, 3'd0, 1'b0, 5'd8,  5'd5};
        tbl[4]  = '{32'hFE312C23, 32'h110, 32'hFFFFFFF8, 3'd2, 1'b0, 5'd2,  5'd24};
        tbl[5]  = '{32'h00208863, 32'h114, 32'h00000010, 3'd0, 1'b0, 5'd1,  5'd16};
        tbl[6]  = '{32'h0000005B, 32'h118, 32'h00000000, 3'd0, 1'b1, 5'd0,  5'd0};
        tbl[7]  = '{32'hFFFFF097, 32'h11C, 32'hFFFFF000, 3'd0, 1'b0, 5'd31, 5'd1};
        tbl[8]  = '{32'h40315093, 32'h120, 32'h00000403, 3'd5, 1'b0, 5'd2,  5'd1};
        tbl[9]  = '{32'h008280E7, 32'h124, 32'h00000008, 3'd0, 1'b0, 5'd5,  5'd1};
        tbl[10] = '{32'h00000073, 32'h128, 32'h00000000, 3'd0, 1'b0, 5'd0,  5'd0};
        tbl[11] = '{32'h00000010, 32'h12C, 32'h00000000, 3'd0, 1'b1, 5'd0,  5'd0};

        // Reset state.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick;
        tick;
        chk("rst_x_valid", 32'(bus_a.x_valid_o), 32'd0);
        chk("rst_f_stall", 32'(bus_a.f_stall_o), 32'd0);
        chk("rst_x_pc", bus_a.x_pc_o, 32'h0);
        chk("rst_x_pc_n", bus_b.x_pc_o, 32'h80);
        chk("rst_x_imm", bus_a.x_imm_o, 32'h0);
        chk("rst_x_rd", 32'(bus_a.x_rd_o), 32'd0);
        chk("rst_x_illegal", 32'(bus_a.x_illegal_o), 32'd0);
        rst = 1'b0;

        // Table-driven stream, one word per cycle, no stalls.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].ir, tbl[i].pc, 1'b0, 1'b0);
            #1;
            chk($sformatf("v%0d_rf_rs1", i), 32'(bus_a.rf_rs1_o), 32'(tbl[i].rs1));
            tick;
            chk($sformatf("v%0d_x_valid", i), 32'(bus_a.x_valid_o), 32'd1);
            chk($sformatf("v%0d_x_pc", i), bus_a.x_pc_o, tbl[i].pc);
            chk($sformatf("v%0d_x_imm", i), bus_a.x_imm_o, tbl[i].imm);
            chk($sformatf("v%0d_x_fun", i), 32'(bus_a.x_fun_o), 32'(tbl[i].fun));
            chk($sformatf("v%0d_x_illegal", i), 32'(bus_a.x_illegal_o), 32'(tbl[i].ill));
            chk($sformatf("v%0d_x_rs1", i), 32'(bus_a.x_rs1_o), 32'(tbl[i].rs1));
            chk($sformatf("v%0d_x_rd", i), 32'(bus_a.x_rd_o), 32'(tbl[i].rd));
            chk($sformatf("v%0d_n_imm", i), bus_b.x_imm_o, tbl[i].imm);
            chk($sformatf("v%0d_n_illegal", i), 32'(bus_b.x_illegal_o), 32'd0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        chk("idle_x_valid", 32'(bus_a.x_valid_o), 32'd0);
        chk("idle_x_pc_hold", bus_a.x_pc_o, tbl[11].pc);
        chk("idle_x_illegal_qual", 32'(bus_a.x_illegal_o), 32'd0);

        // Stall for three cycles while three words stream in.
        drive(1'b1, tbl[0].ir, 32'h200, 1'b1, 1'b0);
        #1;
        chk("stl_t0_f_stall", 32'(bus_a.f_stall_o), 32'd0);
        tick;
        chk("stl_t1_x_valid", 32'(bus_a.x_valid_o), 32'd1);
        chk("stl_t1_x_pc", bus_a.x_pc_o, 32'h200);
        chk("stl_t1_f_stall", 32'(bus_a.f_stall_o), 32'd0);
        chk("stl_t1_n_f_stall", 32'(bus_b.f_stall_o), 32'd1);
        drive(1'b1, tbl[9].ir, 32'h204, 1'b1, 1'b0);
        tick;
        chk("stl_t2_f_stall", 32'(bus_a.f_stall_o), 32'd1);
        chk("stl_t2_x_pc", bus_a.x_pc_o, 32'h200);
        drive(1'b1, tbl[8].ir, 32'h208, 1'b1, 1'b0);
        tick;
        chk("stl_t3_f_stall", 32'(bus_a.f_stall_o), 32'd1);
        chk("stl_t3_x_pc", bus_a.x_pc_o, 32'h200);
        chk("stl_t3_rf_rs1_hold", 32'(bus_a.rf_rs1_o), 32'(tbl[0].rs1));
        drive(1'b1, tbl[8].ir, 32'h208, 1'b0, 1'b0);
        #1;
        chk("stl_t3_rf_rs1_drain", 32'(bus_a.rf_rs1_o), 32'(tbl[9].rs1));
        tick;
        chk("stl_t4_x_pc", bus_a.x_pc_o, 32'h204);
        chk("stl_t4_f_stall", 32'(bus_a.f_stall_o), 32'd0);
        tick;
        chk("stl_t5_x_pc", bus_a.x_pc_o, 32'h208);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        chk("stl_t6_x_valid", 32'(bus_a.x_valid_o), 32'd0);

        // Kill with X and skid full and fetch presenting a word.
        drive(1'b1, tbl[1].ir, 32'h300, 1'b1, 1'b0);
        tick;
        drive(1'b1, tbl[5].ir, 32'h304, 1'b1, 1'b0);
        tick;
        chk("kill_pre_f_stall", 32'(bus_a.f_stall_o), 32'd1);
        chk("kill_pre_x_valid", 32'(bus_a.x_valid_o), 32'd1);
        drive(1'b1, tbl[6].ir, 32'h308, 1'b1, 1'b1);
        tick;
        chk("kill_x_valid", 32'(bus_a.x_valid_o), 32'd0);
        chk("kill_f_stall", 32'(bus_a.f_stall_o), 32'd0);
        drive(1'b1, tbl[6].ir, 32'h308, 1'b0, 1'b1);
        tick;
        chk("kill_accept_dropped", 32'(bus_a.x_valid_o), 32'd0);
        drive(1'b1, tbl[10].ir, 32'h30C, 1'b0, 1'b0);
        tick;
        chk("kill_after_x_valid", 32'(bus_a.x_valid_o), 32'd1);
        chk("kill_after_x_pc", bus_a.x_pc_o, 32'h30C);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;

        // Reset mid-stream while stalled with skid full.
        drive(1'b1, tbl[0].ir, 32'h400, 1'b1, 1'b0);
        tick;
        drive(1'b1, tbl[3].ir, 32'h404, 1'b1, 1'b0);
        tick;
        chk("mrst_pre_f_stall", 32'(bus_a.f_stall_o), 32'd1);
        rst = 1'b1;
        tick;
        chk("mrst_x_valid", 32'(bus_a.x_valid_o), 32'd0);
        chk("mrst_x_pc", bus_a.x_pc_o, 32'h0);
        chk("mrst_x_pc_n", bus_b.x_pc_o, 32'h80);
        chk("mrst_f_stall", 32'(bus_a.f_stall_o), 32'd0);
        chk("mrst_x_imm", bus_a.x_imm_o, 32'h0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        chk("mrst_skid_empty", 32'(bus_a.x_valid_o), 32'd0);

        repeat (3) tick;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
